// File: rtl/corefifo_pkg.sv
// Shared sizing helpers and legality limits for the single-clock COREFIFO controller.
package corefifo_pkg;

  localparam int unsigned RamLatMin = 1;
  localparam int unsigned RamLatMax = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra bit so the count can represent a completely full RAM.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit ram_lat_legal(input int unsigned lat);
    return (lat >= RamLatMin) && (lat <= RamLatMax);
  endfunction

endpackage

// File: rtl/corefifo_lat_pipe.sv
// Fixed-length delay line with synchronous active-high clear; aligns DVALID with RAM read data.
module corefifo_lat_pipe #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  logic [Stages-1:0][Width-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= in_i;
      for (int unsigned i = 1; i < Stages; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_o = pipe_q[Stages-1];

endmodule

// File: rtl/corefifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external LSRAM wrapper: pointers, occupancy,
// registered status flags, error pulses and a read-data-valid strobe.
module corefifo_sync_ctrl
  import corefifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned AFULL_TH   = 120,
  parameter int unsigned AEMPTY_TH  = 8,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  WE,
  input  logic                  RE,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic                  DVALID,
  output logic                  RAM_WEN,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic                  RAM_REN,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CntW  = count_width(ADDR_WIDTH);

  if (!ram_lat_legal(RAM_LAT)) begin : gen_bad_ram_lat
    $error("corefifo_sync_ctrl: RAM_LAT must be 1 or 2");
  end

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, udf_q;
  logic                  wr_ok, rd_ok;

  // Acceptance looks only at registered flags: no write-through-read when full,
  // no fall-through when empty.
  assign wr_ok = WE & ~full_q;
  assign rd_ok = RE & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rptr_d = rptr_q + ADDR_WIDTH'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags derive from the next count so they line up with COUNT every cycle.
  always_comb begin
    full_d   = (count_d == CntW'(Depth));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CntW'(AFULL_TH));
    aempty_d = (count_d <= CntW'(AEMPTY_TH));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= WE & full_q;
      udf_q    <= RE & empty_q;
    end
  end

  corefifo_lat_pipe #(
    .Width  (1),
    .Stages (RAM_LAT)
  ) u_dvalid_pipe (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .in_i  (rd_ok),
    .out_o (DVALID)
  );

  assign RAM_WEN   = wr_ok;
  assign RAM_WADDR = wptr_q;
  assign RAM_REN   = rd_ok;
  assign RAM_RADDR = rptr_q;

  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_corefifo_sync_ctrl.sv
// Directed self-checking bench: one controller with a 1-cycle RAM model, one with a 2-cycle model.
module tb_corefifo_sync_ctrl;

  localparam int unsigned Aw = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, we, re, we2, re2;
  logic [7:0] wdata, wdata2;

  logic full, empty, afull, aempty, ovf, udf, dvalid, ram_wen, ram_ren;
  logic [Aw:0] count;
  logic [Aw-1:0] ram_waddr, ram_raddr;

  logic full2, empty2, afull2, aempty2, ovf2, udf2, dvalid2, ram_wen2, ram_ren2;
  logic [Aw:0] count2;
  logic [Aw-1:0] ram_waddr2, ram_raddr2;

  logic [7:0] mem1 [128];
  logic [7:0] mem2 [128];
  logic [7:0] rdata, rdata2_s1, rdata2;

  int checks = 0;
  int failures = 0;

  corefifo_sync_ctrl #(
    .ADDR_WIDTH (Aw), .AFULL_TH (120), .AEMPTY_TH (8), .RAM_LAT (1)
  ) u_dut (
    .CLOCK (clk), .RESET (rst), .WE (we), .RE (re),
    .FULL (full), .EMPTY (empty), .AFULL (afull), .AEMPTY (aempty), .COUNT (count),
    .OVERFLOW (ovf), .UNDERFLOW (udf), .DVALID (dvalid),
    .RAM_WEN (ram_wen), .RAM_WADDR (ram_waddr), .RAM_REN (ram_ren), .RAM_RADDR (ram_raddr)
  );

  corefifo_sync_ctrl #(
    .ADDR_WIDTH (Aw), .AFULL_TH (120), .AEMPTY_TH (8), .RAM_LAT (2)
  ) u_dut_lat2 (
    .CLOCK (clk), .RESET (rst), .WE (we2), .RE (re2),
    .FULL (full2), .EMPTY (empty2), .AFULL (afull2), .AEMPTY (aempty2), .COUNT (count2),
    .OVERFLOW (ovf2), .UNDERFLOW (udf2), .DVALID (dvalid2),
    .RAM_WEN (ram_wen2), .RAM_WADDR (ram_waddr2), .RAM_REN (ram_ren2),
    .RAM_RADDR (ram_raddr2)
  );

  // RAM wrapper models: registered read, read-before-write.
  always @(posedge clk) begin
    if (ram_wen) mem1[ram_waddr] <= wdata;
    if (ram_ren) rdata <= mem1[ram_raddr];
    if (ram_wen2) mem2[ram_waddr2] <= wdata2;
    if (ram_ren2) rdata2_s1 <= mem2[ram_raddr2];
    rdata2 <= rdata2_s1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; we2 = 1'b0; re2 = 1'b0;
    wdata = '0; wdata2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(aempty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(afull), 0);
    check("rst_dvalid", 32'(dvalid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_udf", 32'(udf), 0);

    // Underflow while empty
    re = 1'b1; #1;
    check("udf_ren", 32'(ram_ren), 0);
    tick();
    check("udf_pulse", 32'(udf), 1);
    check("udf_count", 32'(count), 0);
    re = 1'b0; tick();
    check("udf_clear", 32'(udf), 0);

    // WE&RE at COUNT=0: only the write goes through
    we = 1'b1; re = 1'b1; wdata = 8'hA5; #1;
    check("ebnd_wen", 32'(ram_wen), 1);
    check("ebnd_ren", 32'(ram_ren), 0);
    tick();
    check("ebnd_count", 32'(count), 1);
    check("ebnd_empty", 32'(empty), 0);
    check("ebnd_udf", 32'(udf), 1);
    check("ebnd_dvalid", 32'(dvalid), 0);
    we = 1'b0; tick();
    check("ebnd_rd_dv", 32'(dvalid), 1);
    check("ebnd_rd_data", 32'(rdata), 32'h A5);
    check("ebnd_rd_empty", 32'(empty), 1);
    re = 1'b0;

    // Fill with 0..127
    we = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      wdata = 8'(k - 1);
      tick();
      if (k == 8) check("fill_aempty8", 32'(aempty), 1);
      if (k == 9) check("fill_aempty9", 32'(aempty), 0);
      if (k == 119) check("fill_afull119", 32'(afull), 0);
      if (k == 120) check("fill_afull120", 32'(afull), 1);
      if (k == 127) check("fill_full127", 32'(full), 0);
      if (k == 128) begin
        check("fill_full128", 32'(full), 1);
        check("fill_count128", 32'(count), 128);
      end
    end

    // WE held for 3 cycles while full
    wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      check("ovf_wen", 32'(ram_wen), 0);
      tick();
      check("ovf_pulse", 32'(ovf), 1);
      check("ovf_count", 32'(count), 128);
    end
    we = 1'b0; tick();
    check("ovf_clear", 32'(ovf), 0);
    check("ovf_count_after", 32'(count), 128);

    // WE&RE at COUNT=128: only the read goes through
    we = 1'b1; re = 1'b1; #1;
    check("fbnd_wen", 32'(ram_wen), 0);
    check("fbnd_ren", 32'(ram_ren), 1);
    tick();
    check("fbnd_count", 32'(count), 127);
    check("fbnd_full", 32'(full), 0);
    check("fbnd_ovf", 32'(ovf), 1);
    check("fbnd_dv", 32'(dvalid), 1);
    check("fbnd_data", 32'(rdata), 0);
    we = 1'b0;

    // Drain the remaining 1..127
    for (int k = 1; k <= 127; k++) begin
      tick();
      check("drain_dv", 32'(dvalid), 1);
      check("drain_data", 32'(rdata), 32'(k));
      if (k == 127) begin
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
      end
    end
    re = 1'b0; tick();
    check("drain_dv_off", 32'(dvalid), 0);

    // COUNT=50 then 200 cycles of simultaneous access; pointers wrap
    we = 1'b1;
    for (int k = 0; k < 50; k++) begin
      wdata = 8'(k);
      tick();
    end
    check("sim_count_start", 32'(count), 50);
    re = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdata = 8'(50 + i);
      tick();
      check("sim_count", 32'(count), 50);
      check("sim_dv", 32'(dvalid), 1);
      check("sim_data", 32'(rdata), 32'(i));
    end
    we = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      check("sim_drain_data", 32'(rdata), 32'(200 + k));
    end
    re = 1'b0; tick();
    check("sim_empty", 32'(empty), 1);

    // Reset mid-stream with a read issued during reset
    we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wdata = 8'(k);
      tick();
    end
    we = 1'b0; re = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; re = 1'b0;
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(empty), 1);
    check("mrst_aempty", 32'(aempty), 1);
    check("mrst_full", 32'(full), 0);
    check("mrst_dv", 32'(dvalid), 0);
    tick();
    check("mrst_dv2", 32'(dvalid), 0);

    // RAM_LAT=2: burst of 10 reads
    we2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata2 = 8'h30 + 8'(k);
      tick();
    end
    we2 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      re2 = (c < 10);
      #1;
      check("lat2_ren", 32'(ram_ren2), 32'(c < 10));
      tick();
      check("lat2_dv", 32'(dvalid2), 32'((c + 1 >= 2) && (c + 1 <= 11)));
      if ((c + 1 >= 2) && (c + 1 <= 11)) check("lat2_data", 32'(rdata2), 32'(8'h30 + c - 1));
    end
    re2 = 1'b0;

    // RAM_LAT=2: reset while a read is still in the pipe
    we2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wdata2 = 8'(k);
      tick();
    end
    we2 = 1'b0; re2 = 1'b1;
    tick();
    re2 = 1'b0; rst = 1'b1;
    tick();
    check("lat2_rst_dv", 32'(dvalid2), 0);
    rst = 1'b0;
    tick();
    check("lat2_rst_dv2", 32'(dvalid2), 0);
    check("lat2_rst_count", 32'(count2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
